// File: rtl/char_string_renderer_pkg.sv
// Shared definitions for the character string renderer: FSM states, cell geometry
// defaults, colour constants and a few character codes used by callers.
package char_string_renderer_pkg;

  localparam int MAX_CHARS_DEF = 16;
  localparam int CELL_W_DEF    = 8;
  localparam int CELL_H_DEF    = 10;

  localparam logic [5:0] COLOUR_BLACK = 6'h00;
  localparam logic [5:0] COLOUR_WHITE = 6'h3F;

  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_A     = 8'h41;
  localparam logic [7:0] CHAR_K     = 8'h4B;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LATCH = 3'd2,
    ST_SCAN  = 3'd3,
    ST_EMIT  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/char_string_renderer_cell_scan_counter.sv
// Pixel (dx,dy) and character (idx) counters for the cell scan, with end-of-cell
// and end-of-string flags for the renderer FSM.
module char_string_renderer_cell_scan_counter #(
  parameter int CELL_W = 8,
  parameter int CELL_H = 10,
  parameter int IDXW   = 4
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            clear_all,
  input  logic            clear_cell,
  input  logic            advance,
  input  logic [IDXW:0]   count,
  output logic [7:0]      dx,
  output logic [7:0]      dy,
  output logic [IDXW-1:0] idx,
  output logic            last_pixel,
  output logic            last_char
);

  localparam logic [7:0] DX_LAST = 8'(CELL_W - 1);
  localparam logic [7:0] DY_LAST = 8'(CELL_H - 1);

  logic [7:0]      dx_reg;
  logic [7:0]      dy_reg;
  logic [IDXW-1:0] idx_reg;
  logic            dx_wrap;

  assign dx_wrap    = (dx_reg == DX_LAST);
  assign last_pixel = dx_wrap && (dy_reg == DY_LAST);
  // count is never 0 while scanning, so count-1 cannot underflow here
  assign last_char  = ({1'b0, idx_reg} == (count - 1'b1));

  assign dx  = dx_reg;
  assign dy  = dy_reg;
  assign idx = idx_reg;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      dx_reg  <= '0;
      dy_reg  <= '0;
      idx_reg <= '0;
    end else if (clear_all) begin
      dx_reg  <= '0;
      dy_reg  <= '0;
      idx_reg <= '0;
    end else if (clear_cell) begin
      dx_reg <= '0;
      dy_reg <= '0;
    end else if (advance) begin
      if (dx_wrap) begin
        dx_reg <= '0;
        if (dy_reg == DY_LAST) begin
          dy_reg  <= '0;
          idx_reg <= idx_reg + 1'b1;
        end else begin
          dy_reg <= dy_reg + 1'b1;
        end
      end else begin
        dx_reg <= dx_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/char_string_renderer.sv
// Walks a string buffer, scans each glyph cell through the external LUT and issues
// one ready/valid plot request per drawn pixel.
module char_string_renderer
  import char_string_renderer_pkg::*;
#(
  parameter int         MAX_CHARS = MAX_CHARS_DEF,
  parameter int         CELL_W    = CELL_W_DEF,
  parameter int         CELL_H    = CELL_H_DEF,
  parameter bit         DRAW_BG   = 1'b0,
  parameter logic [5:0] BG_COLOUR = COLOUR_BLACK,
  localparam int        IDXW      = $clog2(MAX_CHARS)
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            start,
  input  logic [7:0]      base_x,
  input  logic [7:0]      base_y,
  input  logic [IDXW:0]   char_count,
  input  logic            abort,
  output logic [IDXW-1:0] char_addr,
  input  logic [7:0]      char_code,
  output logic [7:0]      glyph_code,
  output logic [7:0]      glyph_dx,
  output logic [7:0]      glyph_dy,
  input  logic            glyph_en,
  input  logic [5:0]      glyph_colour,
  output logic [7:0]      plot_x,
  output logic [7:0]      plot_y,
  output logic [5:0]      plot_colour,
  output logic            plot_valid,
  input  logic            plot_ready,
  output logic            busy,
  output logic            done
);

  localparam logic [IDXW:0] MAX_COUNT = (IDXW + 1)'(MAX_CHARS);

  state_t          state_reg, state_next;
  logic [7:0]      base_x_reg, base_y_reg, glyph_code_reg;
  logic [IDXW:0]   count_reg;
  logic [7:0]      plot_x_reg, plot_y_reg;
  logic [5:0]      plot_colour_reg;
  logic            plot_valid_reg;

  logic            start_ok, latch_code, advance, load_plot;
  logic [7:0]      dx, dy;
  logic [IDXW-1:0] idx;
  logic            last_pixel, last_char;
  state_t          after_advance;

  char_string_renderer_cell_scan_counter #(
    .CELL_W(CELL_W), .CELL_H(CELL_H), .IDXW(IDXW)
  ) u_counter (
    .clock      (clock),
    .resetn     (resetn),
    .clear_all  (start_ok),
    .clear_cell (latch_code),
    .advance    (advance),
    .count      (count_reg),
    .dx         (dx),
    .dy         (dy),
    .idx        (idx),
    .last_pixel (last_pixel),
    .last_char  (last_char)
  );

  assign after_advance = !last_pixel ? ST_SCAN : (last_char ? ST_DONE : ST_FETCH);

  always_comb begin
    state_next = state_reg;
    start_ok   = 1'b0;
    latch_code = 1'b0;
    advance    = 1'b0;
    load_plot  = 1'b0;
    case (state_reg)
      ST_IDLE: if (start) begin
        start_ok   = 1'b1;
        state_next = (char_count == '0) ? ST_DONE : ST_FETCH;
      end
      ST_FETCH: state_next = ST_LATCH;
      ST_LATCH: begin
        latch_code = 1'b1;
        state_next = ST_SCAN;
      end
      ST_SCAN: if (glyph_en || DRAW_BG) begin
        load_plot  = 1'b1;
        state_next = ST_EMIT;
      end else begin
        advance    = 1'b1;
        state_next = after_advance;
      end
      ST_EMIT: if (plot_ready) begin
        advance    = 1'b1;
        state_next = after_advance;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    // Cancel overrides every other decision taken this cycle
    if (abort) begin
      state_next = ST_IDLE;
      start_ok   = 1'b0;
      latch_code = 1'b0;
      advance    = 1'b0;
      load_plot  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg       <= ST_IDLE;
      base_x_reg      <= '0;
      base_y_reg      <= '0;
      count_reg       <= '0;
      glyph_code_reg  <= '0;
      plot_x_reg      <= '0;
      plot_y_reg      <= '0;
      plot_colour_reg <= '0;
      plot_valid_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (start_ok) begin
        base_x_reg <= base_x;
        base_y_reg <= base_y;
        count_reg  <= (char_count > MAX_COUNT) ? MAX_COUNT : char_count;
      end
      if (latch_code) glyph_code_reg <= char_code;
      if (abort) begin
        plot_valid_reg <= 1'b0;
      end else if (load_plot) begin
        plot_x_reg      <= base_x_reg + 8'(idx * CELL_W) + dx;
        plot_y_reg      <= base_y_reg + dy;
        plot_colour_reg <= glyph_en ? glyph_colour : BG_COLOUR;
        plot_valid_reg  <= 1'b1;
      end else if ((state_reg == ST_EMIT) && plot_ready) begin
        plot_valid_reg <= 1'b0;
      end
    end
  end

  assign char_addr   = idx;
  assign glyph_code  = glyph_code_reg;
  assign glyph_dx    = dx;
  assign glyph_dy    = dy;
  assign plot_x      = plot_x_reg;
  assign plot_y      = plot_y_reg;
  assign plot_colour = plot_colour_reg;
  assign plot_valid  = plot_valid_reg;
  assign busy        = (state_reg != ST_IDLE);
  assign done        = (state_reg == ST_DONE);

endmodule

// File: tb/tb_char_string_renderer.sv
// Bench for char_string_renderer: table vectors, randomized strings and stalls
// checked against a pixel-list model, plus abort/reset and background-fill cases.
module tb_char_string_renderer;
  import char_string_renderer_pkg::*;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [5:0] c;
  } plot_t;

  typedef struct {
    logic [7:0]   bx;
    logic [7:0]   by;
    logic [4:0]   cnt;
    logic [127:0] codes;
    int           mode;
    int           exp_plots;
    int           exp_cycle;
  } vec_t;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic start = 1'b0, start_b = 1'b0, abort = 1'b0;
  logic [7:0] base_x = '0, base_y = '0;
  logic [4:0] char_count = '0;
  logic plot_ready = 1'b0;
  int ready_mode = 0;

  logic [3:0] char_addr_a, char_addr_b;
  logic [7:0] char_code_a = '0, char_code_b = '0;
  logic [7:0] glyph_code_a, glyph_dx_a, glyph_dy_a, glyph_code_b, glyph_dx_b, glyph_dy_b;
  logic glyph_en_a, glyph_en_b;
  logic [5:0] glyph_colour_a, glyph_colour_b;
  logic [7:0] plot_x_a, plot_y_a, plot_x_b, plot_y_b;
  logic [5:0] plot_colour_a, plot_colour_b;
  logic plot_valid_a, plot_valid_b, busy_a, busy_b, done_a, done_b;

  logic [7:0] mem [16];
  int n_cmp = 0, n_bad = 0;
  plot_t cap_a[$], cap_b[$], exp_q[$];
  int done_cnt_a = 0, done_cnt_b = 0;
  logic stall_a = 1'b0;
  plot_t held_a;

  always #5 clock = ~clock;

  // Glyph LUT: a 21-pixel 'K', blank space, and a synthetic pattern for other codes
  function automatic logic [7:0] k_row(input logic [7:0] dy);
    case (dy)
      8'd0: return 8'hC4;  8'd1: return 8'h24;  8'd2: return 8'h14;
      8'd3: return 8'h0C;  8'd4: return 8'h0C;  8'd5: return 8'h14;
      8'd6: return 8'h24;  8'd7: return 8'h44;  8'd8: return 8'h44;
      8'd9: return 8'h84;  default: return 8'h00;
    endcase
  endfunction

  function automatic logic lut_en(input logic [7:0] code, input logic [7:0] dx, input logic [7:0] dy);
    logic [7:0] row;
    if (dx > 8'd7 || dy > 8'd9) return 1'b0;
    if (code == CHAR_K) begin
      row = k_row(dy);
      return row[dx[2:0]];
    end
    if (code == CHAR_SPACE) return 1'b0;
    return ((int'(code) + 3 * int'(dx) + 5 * int'(dy)) % 4) == 0;
  endfunction

  function automatic logic [5:0] lut_col(input logic [7:0] code, input logic [7:0] dx, input logic [7:0] dy);
    if (code == CHAR_K) return 6'h3C;
    return 6'(code + dx + dy) | 6'h01;
  endfunction

  assign glyph_en_a     = lut_en(glyph_code_a, glyph_dx_a, glyph_dy_a);
  assign glyph_colour_a = lut_col(glyph_code_a, glyph_dx_a, glyph_dy_a);
  assign glyph_en_b     = lut_en(glyph_code_b, glyph_dx_b, glyph_dy_b);
  assign glyph_colour_b = lut_col(glyph_code_b, glyph_dx_b, glyph_dy_b);

  always @(posedge clock) begin
    char_code_a <= mem[char_addr_a];
    char_code_b <= mem[char_addr_b];
  end

  char_string_renderer dut_a (
    .clock(clock), .resetn(resetn), .start(start), .base_x(base_x), .base_y(base_y),
    .char_count(char_count), .abort(abort), .char_addr(char_addr_a), .char_code(char_code_a),
    .glyph_code(glyph_code_a), .glyph_dx(glyph_dx_a), .glyph_dy(glyph_dy_a),
    .glyph_en(glyph_en_a), .glyph_colour(glyph_colour_a), .plot_x(plot_x_a), .plot_y(plot_y_a),
    .plot_colour(plot_colour_a), .plot_valid(plot_valid_a), .plot_ready(plot_ready),
    .busy(busy_a), .done(done_a)
  );

  char_string_renderer #(.DRAW_BG(1'b1), .BG_COLOUR(6'h00)) dut_b (
    .clock(clock), .resetn(resetn), .start(start_b), .base_x(base_x), .base_y(base_y),
    .char_count(char_count), .abort(abort), .char_addr(char_addr_b), .char_code(char_code_b),
    .glyph_code(glyph_code_b), .glyph_dx(glyph_dx_b), .glyph_dy(glyph_dy_b),
    .glyph_en(glyph_en_b), .glyph_colour(glyph_colour_b), .plot_x(plot_x_b), .plot_y(plot_y_b),
    .plot_colour(plot_colour_b), .plot_valid(plot_valid_b), .plot_ready(plot_ready),
    .busy(busy_b), .done(done_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitors: capture handshakes, count done pulses, verify stalled requests hold
  always @(posedge clock) begin
    if (!resetn) begin
      stall_a <= 1'b0;
    end else begin
      if (stall_a) begin
        check("stall_valid_held", 64'(plot_valid_a), 64'd1);
        check("stall_plot_held", 64'({plot_x_a, plot_y_a, plot_colour_a}), 64'(held_a));
      end
      if (plot_valid_a && plot_ready && !abort) cap_a.push_back({plot_x_a, plot_y_a, plot_colour_a});
      if (plot_valid_b && plot_ready && !abort) cap_b.push_back({plot_x_b, plot_y_b, plot_colour_b});
      if (done_a) done_cnt_a <= done_cnt_a + 1;
      if (done_b) done_cnt_b <= done_cnt_b + 1;
      stall_a <= plot_valid_a && !plot_ready && !abort;
      held_a  <= {plot_x_a, plot_y_a, plot_colour_a};
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      case (ready_mode)
        0: plot_ready = 1'b0;
        1: plot_ready = 1'b1;
        default: plot_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Reference: list every cell pixel in drawing order, keep lit ones (all if bg)
  task automatic build_exp(input logic [127:0] codes, input logic [7:0] bx, input logic [7:0] by,
                           input int cnt, input bit bg, output int cycles);
    int n;
    logic [7:0] code;
    logic lit;
    exp_q.delete();
    n = (cnt > 16) ? 16 : cnt;
    cycles = 1;
    for (int i = 0; i < n; i++) begin
      code = codes[i*8 +: 8];
      cycles += 2 + 80;
      for (int y = 0; y < 10; y++) begin
        for (int x = 0; x < 8; x++) begin
          lit = lut_en(code, 8'(x), 8'(y));
          if (lit) cycles++;
          if (lit || bg)
            exp_q.push_back({8'(int'(bx) + i * 8 + x), 8'(int'(by) + y),
                             lit ? lut_col(code, 8'(x), 8'(y)) : 6'h00});
        end
      end
    end
  endtask

  task automatic cmp_seq(input string tag, input plot_t got[$]);
    int m;
    m = 0;
    while (m < got.size() && m < exp_q.size() && got[m] == exp_q[m]) m++;
    check({tag, "_n_plots"}, 64'(got.size()), 64'(exp_q.size()));
    check({tag, "_seq_matched"}, 64'(m), 64'(exp_q.size()));
  endtask

  task automatic load_mem(input logic [127:0] codes);
    for (int i = 0; i < 16; i++) mem[i] = codes[i*8 +: 8];
  endtask

  // Runs one string on dut_a; optionally pokes start with other operands at cycle poke
  task automatic run_vec(input string tag, input vec_t v, input int poke, output int cyc);
    int d0, model_cyc, bound;
    load_mem(v.codes);
    ready_mode = v.mode;
    @(negedge clock);
    cap_a.delete();
    d0 = done_cnt_a;
    build_exp(v.codes, v.bx, v.by, int'(v.cnt), 1'b0, model_cyc);
    base_x = v.bx; base_y = v.by; char_count = v.cnt; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    base_x = 8'd99; base_y = 8'd77; char_count = 5'd5;
    cyc = 1;
    bound = 8000;
    while (!done_a && cyc < bound) begin
      if (cyc == poke) start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      cyc++;
    end
    check({tag, "_done_seen"}, 64'(done_a), 64'd1);
    if (v.mode == 1 && v.cnt != 0) check({tag, "_done_cycle_model"}, 64'(cyc), 64'(model_cyc));
    @(negedge clock);
    @(negedge clock);
    check({tag, "_busy_after"}, 64'(busy_a), 64'd0);
    check({tag, "_one_done"}, 64'(done_cnt_a - d0), 64'd1);
    cmp_seq(tag, cap_a);
    $display("%s: base=(%0d,%0d) count=%0d mode=%0d plots=%0d done_cycle=%0d",
             tag, v.bx, v.by, v.cnt, v.mode, cap_a.size(), cyc);
  endtask

  vec_t table_v[5];
  vec_t rv;
  int cyc, nb, ng, d0;

  initial begin
    table_v[0] = '{8'd10,  8'd20,  5'd1,  {16{CHAR_K}},                1, 21, 104};
    table_v[1] = '{8'd250, 8'd5,   5'd3,  {16{CHAR_K}},                1, 63, 310};
    table_v[2] = '{8'd0,   8'd250, 5'd2,  {{15{CHAR_SPACE}}, CHAR_K},  1, 21, 186};
    table_v[3] = '{8'd40,  8'd40,  5'd20, {{15{CHAR_SPACE}}, CHAR_K},  1, 21, 1334};
    table_v[4] = '{8'd1,   8'd2,   5'd0,  {16{CHAR_K}},                1, 0,  1};
    for (int i = 0; i < 16; i++) mem[i] = CHAR_SPACE;

    #12;
    check("reset_outputs_a", 64'({char_addr_a, glyph_code_a, glyph_dx_a, glyph_dy_a, plot_x_a,
          plot_y_a, plot_colour_a, plot_valid_a, busy_a, done_a}), 64'd0);
    check("reset_outputs_b", 64'({plot_valid_b, busy_b, done_b}), 64'd0);
    @(negedge clock);
    resetn = 1'b1;
    repeat (2) @(negedge clock);

    // Table vectors with plot_ready high
    for (int i = 0; i < 5; i++) begin
      run_vec($sformatf("table%0d", i), table_v[i], 0, cyc);
      check($sformatf("table%0d_n_plots_const", i), 64'(cap_a.size()), 64'(table_v[i].exp_plots));
      if (table_v[i].cnt != 0) check($sformatf("table%0d_done_cycle", i), 64'(cyc), 64'(table_v[i].exp_cycle));
      else check("count0_done_by_cycle2", 64'(cyc <= 2), 64'd1);
      if (i == 0 && cap_a.size() > 0) check("first_plot_xy", 64'({cap_a[0].x, cap_a[0].y}), 64'({8'd12, 8'd20}));
      if (i == 1 && cap_a.size() > 42) check("third_cell_wrap_x", 64'(cap_a[42].x), 64'd12);
    end

    // Same 'K' with start poked while busy, then with random stalls
    run_vec("busy_start", table_v[0], 50, cyc);
    check("busy_start_cycle", 64'(cyc), 64'd104);
    rv = table_v[0];
    rv.mode = 2;
    run_vec("stall_k", rv, 0, cyc);

    // Randomized strings, positions, counts and stall patterns
    for (int t = 0; t < 8; t++) begin
      rv.bx = 8'($urandom_range(0, 255));
      rv.by = 8'($urandom_range(0, 255));
      rv.cnt = 5'($urandom_range(0, 17));
      for (int i = 0; i < 16; i++) begin
        case ($urandom_range(0, 2))
          0: rv.codes[i*8 +: 8] = CHAR_K;
          1: rv.codes[i*8 +: 8] = CHAR_SPACE;
          default: rv.codes[i*8 +: 8] = 8'($urandom_range(8'h30, 8'h5A));
        endcase
      end
      rv.mode = int'($urandom_range(1, 2));
      run_vec($sformatf("rand%0d", t), rv, 0, cyc);
    end

    // Abort while a request is stalled
    ready_mode = 0;
    load_mem({16{CHAR_K}});
    d0 = done_cnt_a;
    @(negedge clock);
    base_x = 8'd10; base_y = 8'd20; char_count = 5'd1; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cyc = 0;
    while (!plot_valid_a && cyc < 200) begin
      @(negedge clock);
      cyc++;
    end
    check("abort_valid_reached", 64'(plot_valid_a), 64'd1);
    abort = 1'b1;
    @(posedge clock);
    #1;
    check("abort_valid_dropped", 64'(plot_valid_a), 64'd0);
    check("abort_idle", 64'(busy_a), 64'd0);
    @(negedge clock);
    abort = 1'b0;
    repeat (5) @(negedge clock);
    check("abort_no_done", 64'(done_cnt_a - d0), 64'd0);
    $display("abort: valid_after=%0d busy_after=%0d", plot_valid_a, busy_a);

    // Reset asserted in the middle of a scan
    ready_mode = 1;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (10) @(negedge clock);
    check("prereset_busy", 64'(busy_a), 64'd1);
    #2 resetn = 1'b0;
    #1;
    check("async_reset_outputs", 64'({char_addr_a, glyph_code_a, glyph_dx_a, glyph_dy_a, plot_x_a,
          plot_y_a, plot_colour_a, plot_valid_a, busy_a, done_a}), 64'd0);
    @(negedge clock);
    resetn = 1'b1;
    $display("reset: outputs cleared mid-scan");
    repeat (2) @(negedge clock);

    // Background fill instance, one 'K'
    load_mem({16{CHAR_K}});
    cap_b.delete();
    d0 = done_cnt_b;
    build_exp({16{CHAR_K}}, 8'd10, 8'd20, 1, 1'b1, cyc);
    base_x = 8'd10; base_y = 8'd20; char_count = 5'd1; start_b = 1'b1;
    @(negedge clock);
    start_b = 1'b0;
    cyc = 0;
    while (!done_b && cyc < 400) begin
      @(negedge clock);
      cyc++;
    end
    check("bg_done_seen", 64'(done_b), 64'd1);
    repeat (2) @(negedge clock);
    check("bg_one_done", 64'(done_cnt_b - d0), 64'd1);
    cmp_seq("bg", cap_b);
    nb = 0; ng = 0;
    foreach (cap_b[i]) begin
      if (cap_b[i].c == 6'h00) nb++;
      else if (cap_b[i].c == 6'h3C) ng++;
    end
    check("bg_total", 64'(cap_b.size()), 64'd80);
    check("bg_bg_colour", 64'(nb), 64'd59);
    check("bg_glyph_colour", 64'(ng), 64'd21);
    $display("bg: plots=%0d bg=%0d glyph=%0d", cap_b.size(), nb, ng);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
